// File: rtl/comp_meas_pkg.sv
// Shared types and defaults for the comparator measurement sequencer.
package comp_meas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } meas_state_t;

    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_SAMPLES    = 8;

endpackage

// File: rtl/comp_meas_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Plain two-stage chain; both stages clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/comp_meas_seq.sv
// Comparator/inverter measurement sequencer: enable the analog cell, wait for
// it to settle, take a burst of synchronized samples, count the ones and hand
// the count plus a majority decision out over valid/ready.
//
// state  | meaning
// IDLE   | cell off, waiting for start
// SETTLE | cell enabled, waiting SETTLE_CYC cycles
// SAMPLE | cell enabled, accumulating one synchronized bit per cycle
// DONE   | result presented, waiting for res_ready
module comp_meas_seq
    import comp_meas_pkg::*;
#(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int SAMPLES    = DEF_SAMPLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         comp_in,
    output logic                         comp_en,
    output logic                         busy,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(SAMPLES+1)-1:0] res_ones,
    output logic                         res_major,
    output logic                         start_drop
);

    localparam int CW = $clog2(SAMPLES + 1);

    meas_state_t   state;
    meas_state_t   state_nxt;
    logic [7:0]    cnt;
    logic [CW-1:0] acc;
    logic [CW-1:0] acc_inc;
    logic [CW:0]   acc_dbl;
    logic          comp_sync;
    logic          settle_tc;
    logic          sample_tc;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (comp_in),
        .q   (comp_sync)
    );

    // acc_inc is the count including the current sample; doubling it lets the
    // majority test stay integer (tie -> 0).
    assign acc_inc   = acc + CW'(comp_sync);
    assign acc_dbl   = {acc_inc, 1'b0};
    assign settle_tc = (cnt == 8'(SETTLE_CYC - 1));
    assign sample_tc = (cnt == 8'(SAMPLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_nxt = state;
        comp_en   = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                comp_en = 1'b1;
                if (settle_tc) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                comp_en = 1'b1;
                if (sample_tc) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Phase counter, ones accumulator, result registers and the dropped-start
    // flag. The counter is shared: it restarts at 0 on entry to each timed phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            acc        <= '0;
            res_ones   <= '0;
            res_major  <= 1'b0;
            start_drop <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt        <= '0;
                        acc        <= '0;
                        start_drop <= 1'b0;
                    end
                end
                SETTLE: begin
                    cnt <= settle_tc ? 8'd0 : cnt + 8'd1;
                end
                SAMPLE: begin
                    acc <= acc_inc;
                    cnt <= cnt + 8'd1;
                    if (sample_tc) begin
                        res_ones  <= acc_inc;
                        res_major <= (acc_dbl > (CW+1)'(SAMPLES));
                    end
                end
                default: begin
                end
            endcase
            if (start && (state != IDLE)) begin
                start_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_comp_meas_seq.sv
`timescale 1ns/1ps
module tb_comp_meas_seq;

    localparam int SC = 4;
    localparam int SM = 8;
    localparam int CW = 4;
    localparam int NB = SC + SM;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          comp_in;
    logic          res_ready;
    logic          comp_en;
    logic          busy;
    logic          res_valid;
    logic [CW-1:0] res_ones;
    logic          res_major;
    logic          start_drop;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CW-1:0] ones;
        logic          major;
    } res_t;

    typedef struct {
        logic [15:0]   mask;
        logic [15:0]   spur;
        int            rdy_k;
        bit            always_rdy;
        bit            b2b;
        logic [CW-1:0] eo;
        logic          em;
    } vec_t;

    res_t          sb_q[$];
    vec_t          vecs[7];
    logic [CW-1:0] last_ones;
    logic          last_major;
    logic          last_drop;

    always #5 clk = ~clk;

    comp_meas_seq #(.SETTLE_CYC(SC), .SAMPLES(SM)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .comp_in    (comp_in),
        .comp_en    (comp_en),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_ones   (res_ones),
        .res_major  (res_major),
        .start_drop (start_drop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake must match the oldest expected result.
    always @(negedge clk) begin
        res_t r;
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got ones=%0d major=%0b with nothing expected", res_ones, res_major);
            end else begin
                r = sb_q.pop_front();
                chk("res_ones", res_ones, r.ones);
                chk("res_major", res_major, r.major);
            end
        end
    end

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_busy", busy, 0);
            chk("idle_comp_en", comp_en, 0);
            chk("idle_valid", res_valid, 0);
            chk("hold_ones", res_ones, last_ones);
            chk("hold_major", res_major, last_major);
            chk("hold_drop", start_drop, last_drop);
        end
    endtask

    // Start in the current cycle (T); cycle T+k drives comp_in = mask[k].
    task automatic run_meas(input vec_t v);
        logic drop_exp;
        res_t r;
        drop_exp  = 1'b0;
        start     = 1'b1;
        comp_in   = v.mask[0];
        res_ready = v.always_rdy;
        r.ones    = v.eo;
        r.major   = v.em;
        sb_q.push_back(r);
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("comp_en", comp_en, (k <= NB) ? 1 : 0);
            chk("res_valid", res_valid, (k > NB) ? 1 : 0);
            chk("busy", busy, 1);
            chk("start_drop", start_drop, drop_exp);
            if (k < 16 && v.spur[k[3:0]]) drop_exp = 1'b1;
            start     = (k < 16) ? v.spur[k[3:0]] : 1'b0;
            comp_in   = (k < 16) ? v.mask[k[3:0]] : 1'b0;
            res_ready = v.always_rdy || (k >= v.rdy_k);
            if (k >= v.rdy_k) break;
        end
        step();
        start     = 1'b0;
        comp_in   = 1'b0;
        res_ready = 1'b0;
        chk("busy_after", busy, 0);
        chk("valid_after", res_valid, 0);
        last_ones  = v.eo;
        last_major = v.em;
        last_drop  = drop_exp;
    endtask

    initial begin
        // Sample window is T+3..T+10 (two-flop offset ahead of SAMPLE T+5..T+12).
        //              mask      spur      rdy always b2b ones major
        vecs[0] = '{16'hFFFF, 16'h0000, 15, 1'b0, 1'b0, 4'd8, 1'b1};
        vecs[1] = '{16'h5555, 16'h0000, 13, 1'b0, 1'b0, 4'd4, 1'b0};
        vecs[2] = '{16'h00F8, 16'h2008, 15, 1'b0, 1'b0, 4'd5, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 13, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[4] = '{16'h07F0, 16'h0000, 13, 1'b1, 1'b1, 4'd7, 1'b1};
        vecs[5] = '{16'hF807, 16'h0000, 13, 1'b1, 1'b1, 4'd0, 1'b0};
        vecs[6] = '{16'h0FF8, 16'h0000, 13, 1'b1, 1'b1, 4'd8, 1'b1};

        rst       = 1'b1;
        start     = 1'b0;
        comp_in   = 1'b0;
        res_ready = 1'b0;
        repeat (3) step();
        chk("rst_comp_en", comp_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_ones", res_ones, 0);
        chk("rst_major", res_major, 0);
        chk("rst_drop", start_drop, 0);
        start = 1'b1;
        step();
        chk("rst_dominates_start", busy, 0);
        start      = 1'b0;
        rst        = 1'b0;
        last_ones  = '0;
        last_major = 1'b0;
        last_drop  = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            if (!vecs[i].b2b) idle_gap(3);
            run_meas(vecs[i]);
        end

        // Reset during SAMPLE at T+7 aborts the measurement.
        idle_gap(2);
        start   = 1'b1;
        comp_in = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            start = 1'b0;
            chk("abort_comp_en", comp_en, 1);
            chk("abort_busy", busy, 1);
        end
        rst = 1'b1;
        step();
        chk("abort_comp_en_off", comp_en, 0);
        chk("abort_busy_off", busy, 0);
        chk("abort_valid", res_valid, 0);
        chk("abort_ones_cleared", res_ones, 0);
        chk("abort_major_cleared", res_major, 0);
        rst        = 1'b0;
        comp_in    = 1'b0;
        last_ones  = '0;
        last_major = 1'b0;
        last_drop  = 1'b0;
        res_ready  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("abort_no_valid", res_valid, 0);
            chk("abort_idle", busy, 0);
        end
        res_ready = 1'b0;
        run_meas(vecs[0]);
        idle_gap(2);
        chk("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
